// File: rtl/norm_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | norm_pipe : pipelined FP32 / dual-FP16 leading-zero normaliser     |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+

package norm_pipe_pkg;
  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;
endpackage

module norm_pipe
  import norm_pipe_pkg::*;
#(
  parameter int W     = 28,
  parameter int LAT   = 2,
  parameter int TAG_W = 4,
  parameter int CW    = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_fmt_e          out_fmt,
  output logic [W-1:0]     out_r,
  output logic [CW-1:0]    out_cnt_h,
  output logic [CW-1:0]    out_cnt_l,
  output logic             out_zero_h,
  output logic             out_zero_l,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HW = W / 2;

  function automatic logic [CW-1:0] lzc_full(input logic [W-1:0] v);
    lzc_full = '0;
    for (int i = 0; i < W; i++)
      if (v[i]) lzc_full = CW'(W - 1 - i);
  endfunction

  function automatic logic [CW-1:0] lzc_half(input logic [HW-1:0] v);
    lzc_half = '0;
    for (int i = 0; i < HW; i++)
      if (v[i]) lzc_half = CW'(HW - 1 - i);
  endfunction

  // In FP16 each lane shifts on its own so nothing crosses the midpoint.
  function automatic logic [W-1:0] nshift(input logic [W-1:0] x, input fp_fmt_e f,
                                          input logic [CW-1:0] ch, input logic [CW-1:0] cl);
    logic [HW-1:0] hi;
    logic [HW-1:0] lo;
    begin
      hi = x[W-1:HW] << ch;
      lo = x[HW-1:0] << cl;
      nshift = (f == FP32) ? (x << ch) : {hi, lo};
    end
  endfunction

  logic [LAT-1:0]   valid_q;
  fp_fmt_e          fmt_q  [LAT];
  logic [W-1:0]     data_q [LAT];
  logic [CW-1:0]    cnth_q [LAT];
  logic [CW-1:0]    cntl_q [LAT];
  logic [LAT-1:0]   zh_q;
  logic [LAT-1:0]   zl_q;
  logic [TAG_W-1:0] tag_q  [LAT];

  fp_fmt_e          fmt_d  [LAT];
  logic [W-1:0]     data_d [LAT];
  logic [CW-1:0]    cnth_d [LAT];
  logic [CW-1:0]    cntl_d [LAT];
  logic [LAT-1:0]   zh_d;
  logic [LAT-1:0]   zl_d;
  logic [TAG_W-1:0] tag_d  [LAT];

  logic [LAT-1:0] w_free;
  logic [LAT-1:0] w_in_v;
  logic [LAT-1:0] w_load;
  logic           w_acc;
  logic [CW-1:0]  w_cnt_h;
  logic [CW-1:0]  w_cnt_l;
  logic           w_zh;
  logic           w_zl;

  // A stage can take new data if it, or any stage after it, has a hole,
  // or the output is draining this cycle.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      w_free[k] = out_ready;
      for (int j = k; j < LAT; j++)
        if (!valid_q[j]) w_free[k] = 1'b1;
    end
  end

  assign in_ready = rst_n && !flush && w_free[0];
  assign w_acc    = in_valid && in_ready;
  assign w_in_v   = LAT'({valid_q, w_acc});
  assign w_load   = flush ? '0 : (w_free & w_in_v);

  always_comb begin
    w_cnt_h = (in_fmt == FP32) ? lzc_full(in_x) : lzc_half(in_x[W-1:HW]);
    w_cnt_l = (in_fmt == FP32) ? '0 : lzc_half(in_x[HW-1:0]);
    w_zh    = (in_fmt == FP32) ? (in_x == '0) : (in_x[W-1:HW] == '0);
    w_zl    = (in_fmt == FP16) && (in_x[HW-1:0] == '0);
  end

  always_comb begin
    fmt_d[0]  = in_fmt;
    tag_d[0]  = in_tag;
    cnth_d[0] = w_cnt_h;
    cntl_d[0] = w_cnt_l;
    zh_d[0]   = w_zh;
    zl_d[0]   = w_zl;
    data_d[0] = (LAT == 1) ? nshift(in_x, in_fmt, w_cnt_h, w_cnt_l) : in_x;
    for (int k = 1; k < LAT; k++) begin
      fmt_d[k]  = fmt_q[k-1];
      tag_d[k]  = tag_q[k-1];
      cnth_d[k] = cnth_q[k-1];
      cntl_d[k] = cntl_q[k-1];
      zh_d[k]   = zh_q[k-1];
      zl_d[k]   = zl_q[k-1];
      data_d[k] = (k == 1) ? nshift(data_q[0], fmt_q[0], cnth_q[0], cntl_q[0])
                           : data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      zh_q    <= '0;
      zl_q    <= '0;
      for (int k = 0; k < LAT; k++) begin
        fmt_q[k]  <= FP32;
        data_q[k] <= '0;
        cnth_q[k] <= '0;
        cntl_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (flush)          valid_q[k] <= 1'b0;
        else if (w_free[k]) valid_q[k] <= w_in_v[k];
        if (w_load[k]) begin
          fmt_q[k]  <= fmt_d[k];
          data_q[k] <= data_d[k];
          cnth_q[k] <= cnth_d[k];
          cntl_q[k] <= cntl_d[k];
          zh_q[k]   <= zh_d[k];
          zl_q[k]   <= zl_d[k];
          tag_q[k]  <= tag_d[k];
        end
      end
    end
  end

  assign out_valid  = valid_q[LAT-1];
  assign out_fmt    = fmt_q[LAT-1];
  assign out_r      = data_q[LAT-1];
  assign out_cnt_h  = cnth_q[LAT-1];
  assign out_cnt_l  = cntl_q[LAT-1];
  assign out_zero_h = zh_q[LAT-1];
  assign out_zero_l = zl_q[LAT-1];
  assign out_tag    = tag_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_norm_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_norm_pipe : self-checking bench for norm_pipe (W=28, LAT=2)      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_norm_pipe;
  import norm_pipe_pkg::*;

  localparam int W     = 28;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(W);
  localparam int HW    = W / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  fp_fmt_e          in_fmt;
  logic [W-1:0]     in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  fp_fmt_e          out_fmt;
  logic [W-1:0]     out_r;
  logic [CW-1:0]    out_cnt_h;
  logic [CW-1:0]    out_cnt_l;
  logic             out_zero_h;
  logic             out_zero_l;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  norm_pipe #(.W(W), .LAT(LAT), .TAG_W(TAG_W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_r(out_r),
    .out_cnt_h(out_cnt_h), .out_cnt_l(out_cnt_l), .out_zero_h(out_zero_h),
    .out_zero_l(out_zero_l), .out_tag(out_tag)
  );

  typedef struct {
    fp_fmt_e          fmt;
    logic [W-1:0]     r;
    logic [CW-1:0]    ch;
    logic [CW-1:0]    cl;
    logic             zh;
    logic             zl;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_out  = 0;
  int   base   = 0;
  int   sent   = 0;
  bit   accepted;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Normalise one lane arithmetically: double until the top bit of the lane is set.
  function automatic void norm_lane(input longint unsigned v, input int width,
                                    output longint unsigned r, output int cnt, output bit z);
    r   = v;
    cnt = 0;
    z   = (v == 0);
    if (!z)
      while (r < (64'd1 << (width - 1))) begin
        r = r * 2;
        cnt++;
      end
  endfunction

  function automatic exp_t model(input fp_fmt_e f, input logic [W-1:0] x,
                                 input logic [TAG_W-1:0] t, input int acc);
    exp_t e;
    longint unsigned rh, rl;
    int cnh, cnl;
    bit zhh, zll;
    e.fmt = f;
    e.tag = t;
    e.acc = acc;
    if (f == FP32) begin
      norm_lane(longint'(x), W, rh, cnh, zhh);
      e.r  = W'(rh);
      e.ch = CW'(cnh);
      e.cl = '0;
      e.zh = zhh;
      e.zl = 1'b0;
    end else begin
      norm_lane(longint'(x[W-1:HW]), HW, rh, cnh, zhh);
      norm_lane(longint'(x[HW-1:0]), HW, rl, cnl, zll);
      e.r  = {HW'(rh), HW'(rl)};
      e.ch = CW'(cnh);
      e.cl = CW'(cnl);
      e.zh = zhh;
      e.zl = zll;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_x(input fp_fmt_e f);
    logic [W-1:0]  x;
    logic [HW-1:0] hi, lo;
    x  = W'($urandom) >> $urandom_range(0, W);
    hi = HW'($urandom) >> $urandom_range(0, HW);
    lo = HW'($urandom) >> $urandom_range(0, HW);
    return (f == FP32) ? x : {hi, lo};
  endfunction

  task automatic drive(input fp_fmt_e f, input logic [W-1:0] x, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_fmt   = f;
    in_x     = x;
    in_tag   = t;
  endtask

  // One clock: check handshake and output against the scoreboard, then advance.
  task automatic step();
    logic exp_ir, exp_ov;
    exp_t e;
    #1;
    exp_ir = rst_n && !flush && ((q.size() < LAT) || out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (cyc - q[0].acc) >= LAT;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (out_valid && q.size() > 0) begin
      e = q[0];
      chk("out_fmt",    64'(out_fmt),    64'(e.fmt));
      chk("out_r",      64'(out_r),      64'(e.r));
      chk("out_cnt_h",  64'(out_cnt_h),  64'(e.ch));
      chk("out_cnt_l",  64'(out_cnt_l),  64'(e.cl));
      chk("out_zero_h", 64'(out_zero_h), 64'(e.zh));
      chk("out_zero_l", 64'(out_zero_l), 64'(e.zl));
      chk("out_tag",    64'(out_tag),    64'(e.tag));
      if (out_ready && rst_n) begin
        void'(q.pop_front());
        n_out++;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) q.push_back(model(in_fmt, in_x, in_tag, cyc));
    if (!rst_n || flush) q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_out_valid"}, 64'(out_valid),  64'(0));
    chk({pfx, "_out_r"},     64'(out_r),      64'(0));
    chk({pfx, "_cnt_h"},     64'(out_cnt_h),  64'(0));
    chk({pfx, "_cnt_l"},     64'(out_cnt_l),  64'(0));
    chk({pfx, "_zero_h"},    64'(out_zero_h), 64'(0));
    chk({pfx, "_zero_l"},    64'(out_zero_l), 64'(0));
    chk({pfx, "_tag"},       64'(out_tag),    64'(0));
    chk({pfx, "_fmt"},       64'(out_fmt),    64'(FP32));
  endtask

  initial begin
    fp_fmt_e f;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_fmt = FP32;
    in_x = '0; in_tag = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // FP32 single item, fixed latency
    out_ready = 1'b1;
    drive(FP32, 28'h0000800, 4'd3);
    step();
    in_valid = 1'b0;
    step();
    chk("v22_valid", 64'(out_valid), 64'(1));
    chk("v22_r",     64'(out_r),     64'(28'h8000000));
    chk("v22_cnt_h", 64'(out_cnt_h), 64'(16));
    chk("v22_zh",    64'(out_zero_h), 64'(0));
    chk("v22_tag",   64'(out_tag),   64'(3));
    step();

    // FP16 lane independence and zero lane
    drive(FP16, {14'h0001, 14'h3FFF}, 4'd5);
    step();
    drive(FP16, {14'h0000, 14'h0040}, 4'd6);
    step();
    in_valid = 1'b0;
    chk("v23_r",     64'(out_r),     64'({14'h2000, 14'h3FFF}));
    chk("v23_cnt_h", 64'(out_cnt_h), 64'(13));
    chk("v23_cnt_l", 64'(out_cnt_l), 64'(0));
    step();
    chk("v24_zh",    64'(out_zero_h), 64'(1));
    chk("v24_cnt_h", 64'(out_cnt_h),  64'(0));
    chk("v24_cnt_l", 64'(out_cnt_l),  64'(7));
    chk("v24_r",     64'(out_r),      64'({14'h0000, 14'h2000}));
    chk("v24_zl",    64'(out_zero_l), 64'(0));
    step();

    // Eight items with an output stall in cycles 3..6
    base = n_out;
    sent = 0;
    for (int t = 0; t < 40 && (sent < 8 || q.size() > 0); t++) begin
      out_ready = !(t >= 3 && t <= 6);
      if (sent < 8) begin
        f = fp_fmt_e'(1'($urandom));
        drive(f, rnd_x(f), TAG_W'(sent));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (accepted) sent++;
    end
    chk("s25_sent",    64'(sent),         64'(8));
    chk("s25_outputs", 64'(n_out - base), 64'(8));

    // Alternating formats back-to-back at full rate
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      f = (i % 2 == 1) ? FP16 : FP32;
      drive(f, rnd_x(f), TAG_W'(i));
      step();
      chk("s26_accept", 64'(accepted), 64'(1));
    end
    in_valid = 1'b0;
    step();
    step();
    chk("s26_outputs", 64'(n_out - base), 64'(16));

    // Flush with a coincident input
    drive(FP32, rnd_x(FP32), 4'd9);
    step();
    flush = 1'b1;
    drive(FP16, rnd_x(FP16), 4'd10);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    base = n_out;
    chk("f27_valid", 64'(out_valid), 64'(0));
    repeat (3) step();
    chk("f27_none", 64'(n_out - base), 64'(0));

    // Mid-stream reset
    drive(FP32, rnd_x(FP32) | 28'h1, 4'd11);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    chk_reset_vals("r28");
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("r28_none", 64'(n_out - base), 64'(0));

    // Random traffic with backpressure and occasional flush
    for (int t = 0; t < 400; t++) begin
      f = fp_fmt_e'(1'($urandom));
      in_valid  = ($urandom % 4) != 0;
      in_fmt    = f;
      in_x      = rnd_x(f);
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 50) == 0;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + 2) step();
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/norm_pipe.md
NORM_PIPE -- requirements
Module: norm_pipe

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- W, 28, total fraction width; SHALL be even and at least 8.
- LAT, 2, pipeline register stages from input accept to output; legal range 1..3.
- TAG_W, 4, width of the sideband tag carried alongside each item.
- CW, $clog2(W), width of each count output.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; everything is sampled on the rising edge.
- rst_n, in, 1, reset; synchronous, active-low.
- flush, in, 1, synchronous pipeline clear.
- in_valid, in, 1, input item present.
- in_ready, out, 1, block can accept an item this cycle.
- in_fmt, in, fp_fmt_e, FP32 selects one W-bit lane; FP16 selects two W/2-bit lanes.
- in_x, in, W, fraction to normalise.
- in_tag, in, TAG_W, opaque sideband.
- out_valid, out, 1, output item present.
- out_ready, in, 1, downstream accepts.
- out_fmt, out, fp_fmt_e, fmt of the item at the output.
- out_r, out, W, normalised fraction.
- out_cnt_h, out, CW, leading-zero count of the high lane, or of the full word in FP32.
- out_cnt_l, out, CW, leading-zero count of the low lane; 0 in FP32.
- out_zero_h, out, 1, high lane (or full word in FP32) is all-zero.
- out_zero_l, out, 1, low lane is all-zero; 0 in FP32.
- out_tag, out, TAG_W, in_tag of the item at the output.

Function
REQ-003 FP32: out_cnt_h SHALL equal the number of leading zeros of in_x, counted from bit W-1.
REQ-004 FP32: out_r SHALL equal in_x shifted left by out_cnt_h, zero-filled.
REQ-005 FP16: lane H = in_x[W-1:W/2] and lane L = in_x[W/2-1:0] SHALL each be counted and shifted independently.
REQ-006 FP16: no bit SHALL cross the W/2 boundary in either direction.
REQ-007 All-zero lane: the lane's zero flag SHALL be 1, its count SHALL be 0, and its out_r bits SHALL be 0.
REQ-008 A transfer occurs when valid and ready are both high on the same edge; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 Latency SHALL be exactly LAT cycles from the input transfer to out_valid when there is no backpressure.
REQ-010 Throughput SHALL be one item per cycle under sustained in_valid and out_ready.
REQ-011 Each stage holds a valid bit and SHALL load when it is empty or when its contents move downstream in the same cycle, so bubbles collapse.
REQ-012 in_ready SHALL be combinational from stage-0 occupancy and downstream advance only, never from in_valid.
REQ-013 Items SHALL leave in acceptance order, each with its own fmt, tag and count, including when FP32 and FP16 items are interleaved back-to-back.
REQ-014 Split of combinational work:
- when LAT >= 2, the LZC SHALL be computed by the end of stage 1 and the shift applied in later stages;
- when LAT = 1, the whole operation SHALL be completed in a single stage.
REQ-015 flush=1 SHALL clear every stage valid bit at the next edge and SHALL force in_ready=0 in that cycle.
REQ-016 If flush and an input transfer coincide, flush SHALL win and the item SHALL be discarded.
REQ-017 Data registers SHALL load only on a stage advance; idle stages SHALL not toggle.

Reset
REQ-018 While rst_n=0 at an edge:
- all stage valid bits SHALL clear;
- out_valid SHALL be 0;
- in_ready SHALL be 0.
REQ-019 Output values after reset: out_r, both counts, both zero flags and out_tag SHALL be 0; out_fmt SHALL be FP32.
REQ-020 A reset asserted mid-stream SHALL discard all in-flight items, with no partial item emitted afterward.
REQ-021 in_ready SHALL go high on the first cycle after rst_n returns to 1.

Verification (W=28, LAT=2)
REQ-022 FP32, in_x=28'h0000800, tag=3 -> 2 cycles later: out_r=28'h8000000, cnt_h=16, zero_h=0, tag=3.
REQ-023 FP16, in_x={14'h0001,14'h3FFF} -> out_r={14'h2000,14'h3FFF}, cnt_h=13, cnt_l=0, no cross-lane bits.
REQ-024 FP16, in_x={14'h0000,14'h0040} -> zero_h=1, cnt_h=0, R_h=0, cnt_l=7, R_l=14'h2000.
REQ-025 Stream of 8 items with out_ready=0 for cycles 3-6 -> exactly 8 outputs, in order, tags intact, out_* stable during the stall, in_ready low once both stages are full.
REQ-026 Alternating FP32/FP16 items issued back-to-back -> every output matches a reference model for its own fmt, one per cycle.
REQ-027 Stage 1 full, then flush=1 together with in_valid=1 -> out_valid=0 on the next cycle, and no item is ever emitted.
REQ-028 Stage 1 full, then rst_n=0 for one cycle -> out_valid=0 and all outputs at reset values; in_ready=1 on the cycle after release.
